// File: rtl/dp_sram_tristate.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dp_sram_tristate : output_enable-controlled driver for the SRAM read bus.
// Revision: 1.0
// ---------------------------------------------------------------------------
module dp_sram_tristate #(
  parameter int WIDTH = 32
) (
  input  logic             output_enable,
  input  logic [WIDTH-1:0] data_in,
  output wire  [WIDTH-1:0] data_out
);

  // Purely combinational; swap for a plain mux on targets without internal tristates.
  assign data_out = output_enable ? data_in : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: rtl/dp_sram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dp_sram : simple dual-port SRAM, one write and one registered read port.
// Revision: 1.0
// ---------------------------------------------------------------------------
module dp_sram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  chip_select,
  input  logic                  write_enable,
  input  logic                  output_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output wire  [WIDTH-1:0]      read_data
);

  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic             w_wr_in_range;
  logic             w_rd_in_range;

  // Only matters when DEPTH is not a power of two.
  assign w_wr_in_range = ({1'b0, write_address} < c_DEPTH);
  assign w_rd_in_range = ({1'b0, read_address}  < c_DEPTH);

  // Storage is never reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (rst_n && chip_select && write_enable && w_wr_in_range) begin
      r_mem[write_address] <= write_data;
    end
  end

  // Read-first: the array read sees the value before this edge's write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (chip_select) begin
      r_rdata <= w_rd_in_range ? r_mem[read_address] : '0;
    end
  end

  dp_sram_tristate #(
    .WIDTH (WIDTH)
  ) u_tristate (
    .output_enable (output_enable),
    .data_in       (r_rdata),
    .data_out      (read_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_dp_sram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dp_sram : directed self-checking bench for dp_sram.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dp_sram;

  localparam int WIDTH      = 32;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  chip_select;
  logic                  write_enable;
  logic                  output_enable;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [WIDTH-1:0]      write_data;
  logic [ADDR_WIDTH-1:0] read_address;
  // Pulled-up net: a released (high-Z) bus resolves to all ones.
  tri1  [WIDTH-1:0]      read_data;

  int n_vec  = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] words [DEPTH];

  dp_sram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .chip_select   (chip_select),
    .write_enable  (write_enable),
    .output_enable (output_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .read_address  (read_address),
    .read_data     (read_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; chip_select = 1'b1; write_enable = 1'b0; output_enable = 1'b1;
    write_address = '0; write_data = '0; read_address = '0;
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;

    step(); step();
    check("reset", read_data, 32'h0);

    // Reset has priority over a write strobe.
    write_enable = 1'b1; write_address = 4'd0; write_data = 32'hCAFE_F00D;
    step();
    check("reset_hold", read_data, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      write_address = ADDR_WIDTH'(i); write_data = words[i];
      step();
    end
    write_enable = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      read_address = ADDR_WIDTH'(i);
      step();
      check($sformatf("readback[%0d]", i), read_data, words[i]);
    end

    write_enable = 1'b1; write_address = 4'd3; write_data = 32'hDEAD_BEEF;
    step();
    write_data = 32'h1234_5678; read_address = 4'd3;
    step();
    check("read_first_old", read_data, 32'hDEAD_BEEF);
    write_enable = 1'b0;
    step();
    check("read_first_new", read_data, 32'h1234_5678);

    read_address = 4'd5;
    step();
    check("pre_cs_read", read_data, words[5]);
    chip_select = 1'b0; write_enable = 1'b1; write_address = 4'd5;
    write_data = 32'hFFFF_FFFF; read_address = 4'd0;
    step();
    check("cs_low_hold", read_data, words[5]);
    chip_select = 1'b1; write_enable = 1'b0; read_address = 4'd5;
    step();
    check("cs_low_no_write", read_data, words[5]);

    read_address = 4'd3;
    step();
    check("pre_oe_read", read_data, 32'h1234_5678);
    output_enable = 1'b0;
    #1;
    check("oe_low_released", read_data, 32'hFFFF_FFFF);
    step();
    check("oe_low_still_released", read_data, 32'hFFFF_FFFF);
    output_enable = 1'b1;
    #1;
    check("oe_high_restore", read_data, 32'h1234_5678);

    write_enable = 1'b1; write_address = 4'd7; write_data = 32'hA5A5_5A5A; read_address = 4'd2;
    step();
    check("concurrent_read", read_data, words[2]);
    write_enable = 1'b0; read_address = 4'd7;
    step();
    check("concurrent_write", read_data, 32'hA5A5_5A5A);

    read_address = 4'd0;
    step();
    check("reset_write_dropped", read_data, words[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
